// File: rtl/window_generator_if.sv
// Pixel stream in, 3x3 window stream out. The master side drives pixels;
// the slave side is the window builder.
interface window_generator_if;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        frame_start;
  logic [71:0] pixel_values;
  logic        window_valid;
  logic        frame_done;
  logic        frame_error;

  modport master (
    output pixel_in, pixel_valid, frame_start,
    input  pixel_values, window_valid, frame_done, frame_error
  );

  modport slave (
    input  pixel_in, pixel_valid, frame_start,
    output pixel_values, window_valid, frame_done, frame_error
  );
endinterface

// File: rtl/window_generator.sv
// Streaming 3x3 neighbourhood builder: two line buffers feed a 3-column
// shift register, and a window is emitted for every interior centre pixel.
module window_generator #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  window_generator_if.slave px
);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        col_q, col_d, pos_col;
  logic [RW-1:0]        row_q, row_d, pos_row;
  logic [2:0][2:0][7:0] win_q, win_d;    // [row][col], so bits line up with k=3r+c
  logic [71:0]          pix_q, pix_d;
  logic                 wvld_q, wvld_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [7:0] lb1_mem [IMAGE_WIDTH];
  logic [7:0] lb2_mem [IMAGE_WIDTH];
  logic [7:0] lb1_rd, lb2_rd;
  logic       start, take, last_col, last_row, emit;

  always_comb begin
    start    = px.pixel_valid & px.frame_start;
    take     = px.pixel_valid & (start | (state_q == ACTIVE));
    // A frame_start pixel is always (0,0), regardless of where the counters were.
    pos_col  = start ? '0 : col_q;
    pos_row  = start ? '0 : row_q;
    lb1_rd   = lb1_mem[pos_col];
    lb2_rd   = lb2_mem[pos_col];
    last_col = (pos_col == CW'(IMAGE_WIDTH - 1));
    last_row = (pos_row == RW'(IMAGE_HEIGHT - 1));
    emit     = take && (pos_row >= RW'(2)) && (pos_col >= CW'(2));

    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    pix_d   = pix_q;
    wvld_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q | (start & (state_q == ACTIVE));

    if (take) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = px.pixel_in;

      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d   = pos_row + 1'b1;
          state_d = ACTIVE;
        end
      end else begin
        col_d   = pos_col + 1'b1;
        row_d   = pos_row;
        state_d = ACTIVE;
      end

      wvld_d = emit;
      done_d = emit & last_col & last_row;
      if (emit) pix_d = win_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      pix_q   <= '0;
      wvld_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      pix_q   <= pix_d;
      wvld_q  <= wvld_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Line buffers need no reset: rows 0-1 of a frame rewrite them before any window uses them.
  always_ff @(posedge clk) begin
    if (take) begin
      lb2_mem[pos_col] <= lb1_rd;
      lb1_mem[pos_col] <= px.pixel_in;
    end
  end

  assign px.pixel_values = pix_q;
  assign px.window_valid = wvld_q;
  assign px.frame_done   = done_q;
  assign px.frame_error  = err_q;
endmodule

// File: doc/window_generator.md
# window_generator

Streaming 3x3 neighbourhood builder that sits in front of the convolution filters (gaussian, and any other filter using the same 72-bit window input). It accepts RGB332 pixels in raster order, one per valid cycle, buffers the two previous image lines, and emits a registered 72-bit window of nine pixels whenever a complete 3x3 neighbourhood is available. Border pixels are not padded; only interior centres produce windows.

## Interface
- IMAGE_WIDTH, 640, pixels per line; legal range 3..4096
- IMAGE_HEIGHT, 480, lines per frame; legal range 3..4096
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- pixel_in  input  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}
- pixel_valid  input  1  pixel_in is accepted this cycle
- frame_start  input  1  qualifies the accepted pixel as pixel (0,0); ignored unless pixel_valid=1
- pixel_values  output  72  3x3 window; pixel k=3*r+c at bits [8k+7:8k], r=0 top row, c=0 left column
- window_valid  output  1  pixel_values is a new window this cycle
- frame_done  output  1  one-cycle pulse with the last window of a frame
- frame_error  output  1  sticky; set by frame_start received mid-frame; cleared by reset only

## Operation
- States: IDLE (awaiting frame_start), ACTIVE (receiving frame).
- IDLE: pixels without frame_start are dropped. pixel_valid & frame_start → ACTIVE, pixel taken as (0,0).
- ACTIVE: each accepted pixel advances col (0..IMAGE_WIDTH-1); col wrap increments row. Accepting (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) → IDLE.
- ACTIVE with pixel_valid & frame_start: set frame_error, restart counters, take pixel as (0,0) of the new frame; line buffer contents are stale but never emitted before rows 0–1 of the new frame are rewritten.
- Line buffers: two IMAGE_WIDTH x 8 memories, LB1 = row-1, LB2 = row-2. On accept at column col: read LB1[col], LB2[col]; write LB2[col]←LB1[col], LB1[col]←pixel_in. Read-before-write at same address within the cycle.
- Window shift register: 3 columns x 3 rows; on accept, shift left by one column, new right column = {LB2[col], LB1[col], pixel_in} for rows {0,1,2}.
- Window emitted for accepted pixel (r,c) iff r≥2 and c≥2; centre = (r-1,c-1). Windows never span a line wrap.
- Windows per frame = (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2).
- No backpressure: downstream must consume every window_valid cycle.
- Idle cycles (pixel_valid=0) hold all state; pixel_values holds last window.

## Timing
- Reset values: pixel_values=0, window_valid=0, frame_done=0, frame_error=0, row=col=0, state IDLE. Line buffer contents undefined and never observed before rewrite.
- Latency: window_valid and pixel_values registered, asserted the cycle after the rising edge accepting pixel (r,c); window_valid high exactly one cycle per qualifying accept.
- Back-to-back: sustained one window per cycle at 100% pixel_valid duty.
- frame_done coincides with window_valid for the window centred at (IMAGE_HEIGHT-2, IMAGE_WIDTH-2).
- frame_start on the cycle after the last pixel of a frame is legal (no error, no gap required).
- rst_n assertion mid-frame: outputs clear asynchronously; next frame requires frame_start.

## Test plan
- 4x4 frame, pixel = 4r+c, continuous valid → 4 windows; first = {0,1,2,4,5,6,8,9,10} (k=0..8), last = {5,6,7,9,10,11,13,14,15} with frame_done=1.
- Same frame with pixel_valid toggling randomly (~50%) → identical window sequence, window_valid only one cycle after each qualifying accept.
- 100 pixels without frame_start in IDLE, then valid frame → no windows before frame, frame output as scenario 1.
- frame_start at pixel (2,1) of a 4x4 frame then full new frame → frame_error=1, exactly 4 windows from new frame, none containing old pixels.
- Two consecutive 5x3 frames back-to-back, values 8'h00..8'h0E then 8'h80..8'h8E → 3 windows each, two frame_done pulses, frame_error=0.
- rst_n low mid-frame (after pixel (2,3) of 4x4) → window_valid/pixel_values=0 immediately; pixels until next frame_start ignored.
